// File: rtl/deal_ctrl_pkg.sv
// Shared types, rule thresholds and card helper for the baccarat deal controller.
package deal_ctrl_pkg;

  localparam int unsigned SCORE_W = 4;
  localparam int unsigned RANK_W  = 4;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_P1     = 4'd1,
    S_D1     = 4'd2,
    S_P2     = 4'd3,
    S_D2     = 4'd4,
    S_EVAL1  = 4'd5,
    S_P3     = 4'd6,
    S_EVAL2  = 4'd7,
    S_D3     = 4'd8,
    S_RESULT = 4'd9,
    S_DONE   = 4'd10
  } state_t;

  localparam logic [SCORE_W-1:0] NATURAL_MIN     = SCORE_W'(8);
  localparam logic [SCORE_W-1:0] PLAYER_DRAW_MAX = SCORE_W'(5);
  localparam logic [SCORE_W-1:0] BANKER_STAND    = SCORE_W'(7);

  // Baccarat point value of a rank: tens and faces count zero.
  function automatic logic [SCORE_W-1:0] card_value(input logic [RANK_W-1:0] rank);
    if (rank >= RANK_W'(10)) begin
      return SCORE_W'(0);
    end
    return SCORE_W'(rank);
  endfunction

endpackage

// File: rtl/banker_draw_rule.sv
// Banker third-card table, applied once the player has drawn a third card.
module banker_draw_rule
  import deal_ctrl_pkg::*;
(
  input  logic [SCORE_W-1:0] dscore,
  input  logic [RANK_W-1:0]  pcard3,
  output logic               draw
);

  logic [SCORE_W-1:0] v;

  // Decide draw from banker score and the player's third-card value.
  always_comb begin
    v    = card_value(pcard3);
    draw = 1'b0;
    case (dscore)
      SCORE_W'(0), SCORE_W'(1), SCORE_W'(2): draw = 1'b1;
      SCORE_W'(3): draw = (v != SCORE_W'(8));
      SCORE_W'(4): draw = (v >= SCORE_W'(2)) && (v <= BANKER_STAND);
      SCORE_W'(5): draw = (v >= SCORE_W'(4)) && (v <= BANKER_STAND);
      SCORE_W'(6): draw = (v >= SCORE_W'(6)) && (v <= BANKER_STAND);
      default:     draw = 1'b0;
    endcase
  end

endmodule

// File: rtl/deal_controller.sv
// Baccarat dealing sequencer: load strobes, third-card rules and win lights.
// Optional DEAL_CTRL_STEP_EN adds a 'step' input that gates every state advance.
module deal_controller
  import deal_ctrl_pkg::*;
(
  input  logic               slow_clock,
  input  logic               resetb,
`ifdef DEAL_CTRL_STEP_EN
  input  logic               step,
`endif
  input  logic [SCORE_W-1:0] pscore,
  input  logic [SCORE_W-1:0] dscore,
  input  logic [RANK_W-1:0]  pcard3,
  output logic               load_pcard1,
  output logic               load_pcard2,
  output logic               load_pcard3,
  output logic               load_dcard1,
  output logic               load_dcard2,
  output logic               load_dcard3,
  output logic               player_win_light,
  output logic               dealer_win_light,
  output logic               game_done
);

  state_t state;
  state_t next_state;
  state_t seq_state;
  logic   banker_draw;
  logic   advance;

`ifdef DEAL_CTRL_STEP_EN
  assign advance = step;
`else
  assign advance = 1'b1;
`endif

  banker_draw_rule u_banker_draw_rule (
    .dscore (dscore),
    .pcard3 (pcard3),
    .draw   (banker_draw)
  );

  // Dealing order and third-card decisions; holds when not advancing.
  always_comb begin
    seq_state = state;
    case (state)
      S_IDLE:  seq_state = S_P1;
      S_P1:    seq_state = S_D1;
      S_D1:    seq_state = S_P2;
      S_P2:    seq_state = S_D2;
      S_D2:    seq_state = S_EVAL1;
      S_EVAL1: begin
        if ((pscore >= NATURAL_MIN) || (dscore >= NATURAL_MIN)) begin
          seq_state = S_RESULT;
        end else if (pscore <= PLAYER_DRAW_MAX) begin
          seq_state = S_P3;
        end else if (dscore <= PLAYER_DRAW_MAX) begin
          seq_state = S_D3;
        end else begin
          seq_state = S_RESULT;
        end
      end
      S_P3:     seq_state = S_EVAL2;
      S_EVAL2:  seq_state = banker_draw ? S_D3 : S_RESULT;
      S_D3:     seq_state = S_RESULT;
      S_RESULT: seq_state = S_DONE;
      S_DONE:   seq_state = S_DONE;
      default:  seq_state = S_IDLE;
    endcase
    next_state = advance ? seq_state : state;
  end

  // State register with Moore outputs registered from the next state.
  always_ff @(posedge slow_clock) begin
    if (!resetb) begin
      state            <= S_IDLE;
      load_pcard1      <= 1'b0;
      load_pcard2      <= 1'b0;
      load_pcard3      <= 1'b0;
      load_dcard1      <= 1'b0;
      load_dcard2      <= 1'b0;
      load_dcard3      <= 1'b0;
      player_win_light <= 1'b0;
      dealer_win_light <= 1'b0;
      game_done        <= 1'b0;
    end else begin
      state       <= next_state;
      load_pcard1 <= (next_state == S_P1);
      load_dcard1 <= (next_state == S_D1);
      load_pcard2 <= (next_state == S_P2);
      load_dcard2 <= (next_state == S_D2);
      load_pcard3 <= (next_state == S_P3);
      load_dcard3 <= (next_state == S_D3);
      game_done   <= (next_state == S_DONE);
      if ((state == S_RESULT) && (next_state == S_DONE)) begin
        player_win_light <= (pscore >= dscore);
        dealer_win_light <= (dscore >= pscore);
      end
    end
  end

endmodule

// File: tb/tb_deal_controller.sv
// Self-checking bench for deal_controller: directed and random games against a rule model.
module tb_deal_controller;

  logic       slow_clock = 1'b0;
  logic       resetb = 1'b0;
  logic       step = 1'b1;
  logic [3:0] pscore = 4'd0;
  logic [3:0] dscore = 4'd0;
  logic [3:0] pcard3 = 4'd0;
  logic load_pcard1, load_pcard2, load_pcard3;
  logic load_dcard1, load_dcard2, load_dcard3;
  logic player_win_light, dealer_win_light, game_done;

  int checks = 0;
  int failures = 0;

  localparam int V_P1 = 32;
  localparam int V_D1 = 16;
  localparam int V_P2 = 8;
  localparam int V_D2 = 4;
  localparam int V_P3 = 2;
  localparam int V_D3 = 1;

  deal_controller dut (
    .slow_clock       (slow_clock),
    .resetb           (resetb),
`ifdef DEAL_CTRL_STEP_EN
    .step             (step),
`endif
    .pscore           (pscore),
    .dscore           (dscore),
    .pcard3           (pcard3),
    .load_pcard1      (load_pcard1),
    .load_pcard2      (load_pcard2),
    .load_pcard3      (load_pcard3),
    .load_dcard1      (load_dcard1),
    .load_dcard2      (load_dcard2),
    .load_dcard3      (load_dcard3),
    .player_win_light (player_win_light),
    .dealer_win_light (dealer_win_light),
    .game_done        (game_done)
  );

  always #5 slow_clock = ~slow_clock;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int loads();
    return {26'd0, load_pcard1, load_dcard1, load_pcard2, load_dcard2, load_pcard3, load_dcard3};
  endfunction

  function automatic int lights();
    return {30'd0, player_win_light, dealer_win_light};
  endfunction

  // Banker table from the game rules, on the player's third-card point value.
  function automatic bit banker_draws(input int ds, input int rank);
    int v;
    v = (rank >= 10) ? 0 : rank;
    if (ds <= 2) return 1'b1;
    if (ds == 3) return v != 8;
    if (ds == 4) return v >= 2 && v <= 7;
    if (ds == 5) return v >= 4 && v <= 7;
    if (ds == 6) return v >= 6 && v <= 7;
    return 1'b0;
  endfunction

  task automatic do_reset();
    resetb = 1'b0;
    pscore = 4'd0;
    dscore = 4'd0;
    pcard3 = 4'd0;
    step   = 1'b1;
    @(posedge slow_clock);
    #1;
    check("rst_loads", loads(), 0);
    check("rst_lights", lights(), 0);
    check("rst_done", int'(game_done), 0);
    resetb = 1'b1;
  endtask

  // One game: ps/ds are two-card scores, psf/dsf the scores after any third card.
  task automatic run_game(input int ps, input int ds, input int rank, input int psf,
                          input int dsf, input int hold, input bit abort_p3);
    int q[$];
    bit natural, pdraw, ddraw;
    bit in_p3, in_d3, left_p3, left_d3;
    int fps, fds, expl;
    do_reset();
    natural = (ps >= 8) || (ds >= 8);
    pdraw   = !natural && (ps <= 5);
    if (natural)    ddraw = 1'b0;
    else if (pdraw) ddraw = banker_draws(ds, rank);
    else            ddraw = (ds <= 5);
    q = '{V_P1, V_D1, V_P2, V_D2, 0};
    if (pdraw) begin
      q.push_back(V_P3);
      q.push_back(0);
    end
    if (ddraw) q.push_back(V_D3);
    q.push_back(0);
    fps = pdraw ? psf : ps;
    fds = ddraw ? dsf : ds;
    in_p3 = 0; in_d3 = 0; left_p3 = 0; left_d3 = 0;
    for (int i = 0; i < q.size(); i++) begin
      pscore = 4'(left_p3 ? psf : ps);
      dscore = 4'(left_d3 ? dsf : ds);
      pcard3 = 4'(left_p3 ? rank : 0);
      @(posedge slow_clock);
      #1;
      if (in_p3) left_p3 = 1;
      if (in_d3) left_d3 = 1;
      in_p3 = (q[i] == V_P3);
      in_d3 = (q[i] == V_D3);
      check($sformatf("loads_e%0d", i + 1), loads(), q[i]);
      check($sformatf("done_e%0d", i + 1), int'(game_done), 0);
      check($sformatf("lights_e%0d", i + 1), lights(), 0);
      if (abort_p3 && in_p3) return;
    end
    pscore = 4'(fps);
    dscore = 4'(fds);
    pcard3 = 4'(pdraw ? rank : 0);
    expl = ((fps >= fds) ? 2 : 0) + ((fds >= fps) ? 1 : 0);
    @(posedge slow_clock);
    #1;
    check($sformatf("done_e%0d", q.size() + 1), int'(game_done), 1);
    check("lights_final", lights(), expl);
    check("loads_final", loads(), 0);
    for (int h = 0; h < hold; h++) begin
      pscore = 4'($urandom_range(9));
      dscore = 4'($urandom_range(9));
      @(posedge slow_clock);
      #1;
      check("lights_held", lights(), expl);
      check("done_held", int'(game_done), 1);
      check("loads_held", loads(), 0);
    end
  endtask

  initial begin
    // Mid-game reset while in S_P3, then a full game that must restart at P1.
    run_game(4, 6, 7, 5, 9, 0, 1'b1);
    // Natural.
    run_game(8, 3, 5, 0, 0, 2, 1'b0);
    // Player draws; banker draws on value 7, stands on a queen.
    run_game(4, 6, 7, 5, 3, 2, 1'b0);
    run_game(4, 6, 12, 5, 3, 2, 1'b0);
    // Player stands, dealer draws to 9.
    run_game(6, 5, 0, 6, 9, 2, 1'b0);
    // Tie held for 20 edges.
    run_game(7, 7, 0, 0, 0, 20, 1'b0);
    // Random games.
    for (int g = 0; g < 60; g++) begin
      run_game(int'($urandom_range(9)), int'($urandom_range(9)), int'($urandom_range(13)),
               int'($urandom_range(9)), int'($urandom_range(9)), int'($urandom_range(3)), 1'b0);
    end
`ifdef DEAL_CTRL_STEP_EN
    // Step gating: park in S_D1 for five edges, then advance one state per pulse.
    do_reset();
    pscore = 4'd4;
    dscore = 4'd6;
    repeat (2) @(posedge slow_clock);
    #1;
    check("step_d1", loads(), V_D1);
    step = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge slow_clock);
      #1;
      check("step_hold", loads(), V_D1);
    end
    step = 1'b1;
    @(posedge slow_clock);
    #1;
    step = 1'b0;
    check("step_p2", loads(), V_P2);
    @(posedge slow_clock);
    #1;
    check("step_p2_hold", loads(), V_P2);
    step = 1'b1;
    @(posedge slow_clock);
    #1;
    step = 1'b0;
    check("step_d2", loads(), V_D2);
    @(posedge slow_clock);
    #1;
    check("step_d2_hold", loads(), V_D2);
    step = 1'b1;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
